// File: rtl/pwm_multi_controller.sv
// Multi-channel PWM generator with shadowed compare registers that reload only at the period boundary.
// Optional build macro PWM_CENTER_ALIGNED_EN selects up/down (center-aligned) counting.
module pwm_multi_controller #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHANNELS     = 2,
  parameter int PERIOD_COUNT = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_ce,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           enable,
  input  logic                           ovr_clr,
  output logic                           o_ce,
  output logic [CHANNELS-1:0]            pwm_out,
  output logic                           overrun,
  output logic                           running
);

  localparam int CW   = (PERIOD_COUNT > 0) ? $clog2(PERIOD_COUNT + 1) : 1;
  localparam int CMPW = (DATA_WIDTH > CW) ? DATA_WIDTH : CW;
  localparam logic [CW-1:0] PC_V = CW'(PERIOD_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [CHANNELS*DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS*DATA_WIDTH-1:0] active_q, active_d;
  logic                           shadow_valid_q, shadow_valid_d;
  logic                           overrun_q, overrun_d;
  logic [CHANNELS-1:0]            pwm_q, pwm_d;
  logic                           period_end;
  logic                           load;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)          state_d = RUN;
        else if (period_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PWM_CENTER_ALIGNED_EN
  logic down_q, down_d;

  // The period boundary is the bottom turn-around: cnt==0 while still heading down.
  assign period_end = (cnt_q == '0) && down_q;

  always_comb begin
    cnt_d  = '0;
    down_d = 1'b0;
    if (state_q != IDLE) begin
      if (down_q) begin
        cnt_d  = (cnt_q == '0) ? cnt_q + 1'b1 : cnt_q - 1'b1;
        down_d = (cnt_q != '0);
      end else if (cnt_q == PC_V) begin
        cnt_d  = cnt_q - 1'b1;
        down_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
    if (state_d == IDLE) begin
      cnt_d  = '0;
      down_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) down_q <= 1'b0;
    else        down_q <= down_d;
  end
`else
  assign period_end = (cnt_q == PC_V);

  always_comb begin
    cnt_d = '0;
    if ((state_q != IDLE) && (cnt_q != PC_V)) cnt_d = cnt_q + 1'b1;
  end
`endif

  // The first period after IDLE also picks up a pending sample.
  assign load = (state_q == IDLE) ? enable : period_end;

  always_comb begin
    shadow_d       = i_ce ? data_in : shadow_q;
    active_d       = (load && shadow_valid_q) ? shadow_q : active_q;
    shadow_valid_d = i_ce | (shadow_valid_q & ~load);
    overrun_d      = (i_ce & shadow_valid_q & ~load) | (overrun_q & ~ovr_clr);
  end

  always_comb begin
    pwm_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pwm_d[k] = (state_q != IDLE) &&
                 (CMPW'(cnt_q) < CMPW'(active_q[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      shadow_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      pwm_q          <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      shadow_valid_q <= shadow_valid_d;
      overrun_q      <= overrun_d;
      pwm_q          <= pwm_d;
    end
  end

  assign o_ce    = (state_q == RUN) && period_end;
  assign pwm_out = pwm_q;
  assign overrun = overrun_q;
  assign running = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_multi_controller.sv
// Bench for pwm_multi_controller (edge-aligned build): two instances (terminal counts 255 and 254)
// share one stimulus stream and are checked every cycle against a behavioural period model.
module tb_pwm_multi_controller;
  localparam int DW = 8;
  localparam int CH = 2;
  localparam int W  = CH * DW;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst_n, i_ce, enable, ovr_clr;
  logic [W-1:0]  data_in;
  logic          o_ce0, ovr0, run0, o_ce1, ovr1, run1;
  logic [CH-1:0] pwm0, pwm1;
  int checks   = 0;
  int failures = 0;

  int            pcs[2] = '{255, 254};
  int            m_st[2];
  int            m_cnt[2];
  logic [W-1:0]  m_sh[2];
  logic [W-1:0]  m_act[2];
  bit            m_sv[2];
  bit            m_ovr[2];
  logic [CH-1:0] m_pwm[2];

  always #5 clk = ~clk;

  pwm_multi_controller #(.DATA_WIDTH(DW), .CHANNELS(CH), .PERIOD_COUNT(255)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_ce(i_ce), .data_in(data_in), .enable(enable),
    .ovr_clr(ovr_clr), .o_ce(o_ce0), .pwm_out(pwm0), .overrun(ovr0), .running(run0));

  pwm_multi_controller #(.DATA_WIDTH(DW), .CHANNELS(CH), .PERIOD_COUNT(254)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_ce(i_ce), .data_in(data_in), .enable(enable),
    .ovr_clr(ovr_clr), .o_ce(o_ce1), .pwm_out(pwm1), .overrun(ovr1), .running(run1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = S_IDLE; m_cnt[d] = 0; m_sh[d] = '0; m_act[d] = '0;
      m_sv[d] = 1'b0; m_ovr[d] = 1'b0; m_pwm[d] = '0;
    end
  endtask

  // One clock of the period model: position in period, pending-sample flag, duty compare.
  task automatic model_step(input int d);
    bit            at_end, ld;
    int            nst;
    logic [CH-1:0] npwm;
    at_end = (m_st[d] != S_IDLE) && (m_cnt[d] == pcs[d]);
    ld     = (m_st[d] == S_IDLE) ? enable : at_end;
    for (int ch = 0; ch < CH; ch++)
      npwm[ch] = (m_st[d] != S_IDLE) && (m_cnt[d] < int'(m_act[d][ch*DW +: DW]));
    if (i_ce && m_sv[d] && !ld) m_ovr[d] = 1'b1;
    else if (ovr_clr)           m_ovr[d] = 1'b0;
    if (ld && m_sv[d]) m_act[d] = m_sh[d];
    m_sv[d] = i_ce ? 1'b1 : (ld ? 1'b0 : m_sv[d]);
    if (i_ce) m_sh[d] = data_in;
    m_cnt[d] = (m_st[d] == S_IDLE) ? 0 : (m_cnt[d] + 1) % (pcs[d] + 1);
    nst = m_st[d];
    case (m_st[d])
      S_IDLE:  if (enable) nst = S_RUN;
      S_RUN:   if (!enable) nst = S_DRAIN;
      default: if (enable) nst = S_RUN; else if (at_end) nst = S_IDLE;
    endcase
    m_st[d]  = nst;
    m_pwm[d] = npwm;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [4:0] act, exp;
        act = (d == 0) ? {o_ce0, run0, ovr0, pwm0} : {o_ce1, run1, ovr1, pwm1};
        exp = {(m_st[d] == S_RUN) && (m_cnt[d] == pcs[d]), m_st[d] != S_IDLE, m_ovr[d], m_pwm[d]};
        check((d == 0) ? "cycle_dut0" : "cycle_dut1", 32'(act), 32'(exp));
      end
    end
  end

  task automatic wait_oce(input int which, input string nm);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 700) begin
      @(negedge clk);
      n++;
      seen = (which == 0) ? o_ce0 : o_ce1;
    end
    check(nm, 32'(seen), 1);
  endtask

  task automatic window0(input int n, output int h0, output int h1, output int first);
    h0 = 0; h1 = 0; first = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      h0 += int'(pwm0[0]);
      h1 += int'(pwm0[1]);
      if (o_ce0 && first == 0) first = k;
    end
  endtask

  task automatic pulse_ice(input logic [W-1:0] v);
    @(posedge clk); #1;
    i_ce = 1'b1; data_in = v;
    @(posedge clk); #1;
    i_ce = 1'b0;
  endtask

  initial begin
    int h0, h1, first, lows;
    rst_n = 1'b1; i_ce = 1'b0; enable = 1'b0; ovr_clr = 1'b0; data_in = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_o_ce", 32'(o_ce0), 0);
    check("reset_pwm", 32'(pwm0), 0);
    check("reset_overrun", 32'(ovr0), 0);
    check("reset_running", 32'(run0), 0);
    rst_n = 1'b1;

    // 50% / 25% duty, period 256
    pulse_ice(16'h4080);
    enable = 1'b1;
    wait_oce(0, "oce_first");
    window0(256, h0, h1, first);
    check("duty_ch0_0x80", 32'(h0), 128);
    check("duty_ch1_0x40", 32'(h1), 64);
    check("oce_period", 32'(first), 256);

    // mid-period update takes effect only after the next boundary
    repeat (50) @(posedge clk);
    #1 i_ce = 1'b1; data_in = 16'h40C0;
    @(posedge clk); #1 i_ce = 1'b0;
    wait_oce(0, "oce_after_update");
    window0(256, h0, h1, first);
    check("duty_ch0_0xC0", 32'(h0), 192);

    // 0xFF on terminal count 254 is solid high, 0x00 solid low
    pulse_ice(16'h00FF);
    wait_oce(1, "oce1_a");
    wait_oce(1, "oce1_b");
    wait_oce(1, "oce1_c");
    h0 = 0; h1 = 0;
    for (int k = 0; k < 255; k++) begin
      @(negedge clk);
      h0 += int'(pwm1[0]);
      h1 += int'(pwm1[1]);
    end
    check("ff_solid_high", 32'(h0), 255);
    check("zero_solid_low", 32'(h1), 0);

    // overrun: two samples inside one period, then clear, then sample on the load cycle
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    wait_oce(0, "oce_pre_ovr");
    repeat (5) @(posedge clk);
    #1 i_ce = 1'b1; data_in = 16'h1020;
    @(posedge clk); #1 data_in = 16'h3040;
    @(posedge clk); #1 i_ce = 1'b0;
    check("overrun_set", 32'(ovr0), 1);
    repeat (20) @(posedge clk);
    #1 check("overrun_sticky", 32'(ovr0), 1);
    ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    check("overrun_clr", 32'(ovr0), 0);
    wait_oce(0, "oce_load_cycle");
    i_ce = 1'b1; data_in = 16'h5060;
    @(posedge clk); #1 i_ce = 1'b0;
    check("overrun_on_load", 32'(ovr0), 0);
    ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;

    // enable dropped at cnt=10: drain to the end of the period, no o_ce, then idle
    wait_oce(0, "oce_pre_drain");
    repeat (11) @(posedge clk);
    #1 enable = 1'b0;
    window0(300, h0, h1, first);
    check("drain_no_oce", 32'(first), 0);
    check("idle_running", 32'(run0), 0);
    check("idle_pwm", 32'(pwm0), 0);

    // re-assert during DRAIN: counting continuous, o_ce one period later
    enable = 1'b1;
    wait_oce(0, "oce_restart");
    lows = 0; first = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (!run0) lows++;
      if (o_ce0 && first == 0) first = k;
      if (k == 20) enable = 1'b0;
      if (k == 60) enable = 1'b1;
    end
    check("drain_reassert_running", 32'(lows), 0);
    check("drain_reassert_oce", 32'(first), 256);

    // asynchronous reset around cnt=100
    repeat (3) @(posedge clk);
    #1 i_ce = 1'b1; data_in = 16'hFFFF;
    @(posedge clk); #1 data_in = 16'hEEEE;
    @(posedge clk); #1 i_ce = 1'b0;
    repeat (95) @(posedge clk);
    #1;
    check("pre_reset_overrun", 32'(ovr0), 1);
    check("pre_reset_running", 32'(run0), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_o_ce", 32'(o_ce0), 0);
    check("async_pwm", 32'(pwm0), 0);
    check("async_overrun", 32'(ovr0), 0);
    check("async_running", 32'(run0), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (!rst_n) rst_n = 1'b1;
      i_ce    = ($urandom_range(0, 99) < 3);
      data_in = W'($urandom);
      ovr_clr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 599) == 0) enable = ~enable;
      if (c == 2500) begin
        #2 rst_n = 1'b0;
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; i_ce = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
